mmio_uart_sequencer: RTL and testbench
======================================

Name: mmio_uart_sequencer

Overview:
- Sequences CPU memory-mapped accesses to the UART peripheral.
- Replaces level-to-pulse edge detection on rd/wr with an explicit request/acknowledge handshake.
- Issues exactly one single-cycle rd_uart/wr_uart strobe per accepted access, with optional blocking on tx_full/rx_empty and a timeout.
- Sits between the datapath MMIO decode (s_mmio qualified) and the uart instance.

Parameters:
- TIMEOUT_CYCLES, 5000000, max cycles a blocking access waits; 0 = wait forever.
- CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived, not overridden).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req  in  1  access request, one-cycle pulse, sampled only in IDLE
- we  in  1  1 = write, 0 = read; sampled with req
- addr  in  2  0 = DATA, 1 = STATUS, 2 = CTRL, 3 = reserved
- wdata  in  8  write data; sampled with req
- rdata  out  8  read data; valid in ack cycle, held until next ack
- ack  out  1  one-cycle completion pulse
- busy  out  1  high from accept until ack inclusive
- rd_uart  out  1  one-cycle pop strobe to uart
- wr_uart  out  1  one-cycle push strobe to uart
- w_data  out  8  data to uart TX FIFO; registered, valid with wr_uart
- r_data  in  8  uart RX FIFO head (valid before pop)
- tx_full  in  1  uart TX FIFO full
- rx_empty  in  1  uart RX FIFO empty

Behaviour:
- Reset: state IDLE; rdata=0, ack=0, busy=0, rd_uart=0, wr_uart=0, w_data=0, block_en=1, err=0, counter=0.
- rst has priority over every event and aborts any access mid-flight with no strobe and no ack.
- FSM states: IDLE, WAIT, ACK.
- IDLE: on req, latch we/addr/wdata, clear counter, go to WAIT; busy=1 from the next cycle. req outside IDLE is ignored; no queueing.
- WAIT, ready condition: DATA write needs !tx_full; DATA read needs !rx_empty; STATUS, CTRL and reserved are always ready.
- WAIT, ready: in the same cycle assert the strobe (wr_uart with w_data=wdata, or rd_uart while capturing r_data into rdata), then go to ACK.
- WAIT, not ready, block_en=0: no strobe; set err; DATA read returns rdata=0; go to ACK.
- WAIT, not ready, block_en=1: increment counter each cycle and stay in WAIT. When counter reaches TIMEOUT_CYCLES-1 (and TIMEOUT_CYCLES≠0), set err, issue no strobe, DATA read returns 0, go to ACK.
- ACK: ack=1 for one cycle, then IDLE; busy drops after ACK.
- Minimum latency: req at cycle 0, strobe at cycle 1, ack at cycle 2. Back-to-back: the next req is accepted at cycle 3.
- STATUS read: rdata={4'b0, err, block_en, tx_full, rx_empty}, sampled in the WAIT cycle.
- CTRL read: rdata={7'b0, block_en}.
- CTRL write: block_en<=wdata[0]; err cleared if wdata[1]=1 (takes priority over a same-cycle set is impossible, since sets occur only on DATA accesses).
- Reserved address: reads 0, writes ignored; acked normally with no strobe.
- STATUS write is ignored and acked.
- err is sticky until a CTRL clear or rst.
- Strobes never assert outside WAIT→ACK transitions; at most one strobe per access.

Decomposition:
- Shared package/include: address constants (ADDR_DATA, ADDR_STATUS, ADDR_CTRL), STATUS bit indices, CTRL bit indices, FSM state encodings.
- No sub-module is needed. The timeout counter is inline.

Test Plan:
- Reset, then read STATUS with tx_full=0, rx_empty=1 → ack at cycle 2, rdata=8'h05 (block_en=1, rx_empty=1).
- DATA write 8'hA5 with tx_full=0 → wr_uart high exactly 1 cycle at cycle 1, w_data=8'hA5, ack at cycle 2.
- Blocking DATA read with rx_empty=1 for 10 cycles, then r_data=8'h3C and rx_empty=0 → rd_uart pulses once, rdata=8'h3C, ack one cycle later, err=0.
- TIMEOUT_CYCLES=16, blocking write with tx_full held 1 → no wr_uart, ack after the timeout, STATUS reads bit3=1; CTRL write 8'h03 clears err (STATUS bit3=0).
- CTRL write 8'h00, then DATA read with rx_empty=1 → immediate ack at cycle 2, rdata=0, no rd_uart, err=1.
- rst asserted during WAIT of a blocking read → no rd_uart, no ack; all outputs 0 and block_en=1 the next cycle; a req pulse during busy is ignored (exactly one ack observed).

Source files
------------

// File: rtl/mmio_uart_sequencer_pkg.sv
// Shared definitions for the MMIO-to-UART access sequencer: register map,
// STATUS/CTRL bit positions and FSM state encoding.
package mmio_uart_sequencer_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int STATUS_RX_EMPTY = 0;
  localparam int STATUS_TX_FULL  = 1;
  localparam int STATUS_BLOCK_EN = 2;
  localparam int STATUS_ERR      = 3;

  localparam int CTRL_BLOCK_EN = 0;
  localparam int CTRL_ERR_CLR  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  function automatic logic [7:0] status_byte(input logic err, input logic block_en,
                                             input logic tx_full, input logic rx_empty);
    logic [7:0] s;
    s = 8'h00;
    s[STATUS_ERR]      = err;
    s[STATUS_BLOCK_EN] = block_en;
    s[STATUS_TX_FULL]  = tx_full;
    s[STATUS_RX_EMPTY] = rx_empty;
    return s;
  endfunction

endpackage

// File: rtl/mmio_uart_sequencer.sv
// Request/acknowledge sequencer between the CPU MMIO decode and the UART:
// one registered rd_uart/wr_uart strobe per access, optional blocking with timeout.
module mmio_uart_sequencer
  import mmio_uart_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ack,
  output logic       busy,
  output logic       rd_uart,
  output logic       wr_uart,
  output logic [7:0] w_data,
  input  logic [7:0] r_data,
  input  logic       tx_full,
  input  logic       rx_empty
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  state_t           state;
  logic             lat_we;
  logic [1:0]       lat_addr;
  logic [7:0]       lat_wdata;
  logic             block_en;
  logic             err;
  logic [CNT_W-1:0] counter;
  logic             ready;
  logic             timeout_hit;

  // Only DATA accesses depend on FIFO state; every other address completes at once.
  always_comb begin
    ready       = 1'b1;
    timeout_hit = 1'b0;
    if (lat_addr == ADDR_DATA) begin
      ready = lat_we ? !tx_full : !rx_empty;
    end else begin
      ready = 1'b1;
    end
    if (TIMEOUT_CYCLES != 0) begin
      timeout_hit = (counter == CNT_LAST);
    end else begin
      timeout_hit = 1'b0;
    end
  end

  // Access FSM with all outputs registered; strobes default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lat_we    <= 1'b0;
      lat_addr  <= ADDR_DATA;
      lat_wdata <= 8'h00;
      block_en  <= 1'b1;
      err       <= 1'b0;
      counter   <= '0;
      rdata     <= 8'h00;
      ack       <= 1'b0;
      busy      <= 1'b0;
      rd_uart   <= 1'b0;
      wr_uart   <= 1'b0;
      w_data    <= 8'h00;
    end else begin
      ack     <= 1'b0;
      rd_uart <= 1'b0;
      wr_uart <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            lat_we    <= we;
            lat_addr  <= addr;
            lat_wdata <= wdata;
            counter   <= '0;
            busy      <= 1'b1;
            state     <= ST_WAIT;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (ready) begin
            state <= ST_ACK;
            case (lat_addr)
              ADDR_DATA: begin
                if (lat_we) begin
                  wr_uart <= 1'b1;
                  w_data  <= lat_wdata;
                end else begin
                  rd_uart <= 1'b1;
                  rdata   <= r_data;
                end
              end
              ADDR_STATUS: begin
                if (!lat_we) rdata <= status_byte(err, block_en, tx_full, rx_empty);
              end
              ADDR_CTRL: begin
                if (lat_we) begin
                  block_en <= lat_wdata[CTRL_BLOCK_EN];
                  if (lat_wdata[CTRL_ERR_CLR]) err <= 1'b0;
                end else begin
                  rdata <= {7'b0000000, block_en};
                end
              end
              default: begin
                if (!lat_we) rdata <= 8'h00;
              end
            endcase
          end else if (!block_en || timeout_hit) begin
            // Failed DATA access: flag it, skip the strobe, still acknowledge.
            err   <= 1'b1;
            state <= ST_ACK;
            if (!lat_we) rdata <= 8'h00;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        ST_ACK: begin
          ack   <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_sequencer.sv
// Directed bench: a transaction-level model predicts the per-cycle output timeline
// of each access; a negedge compare process checks the DUT against it every cycle.
module tb_mmio_uart_sequencer;

  localparam int T = 16;
  localparam int N = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       we = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] r_data = 8'h00;
  logic       tx_full = 1'b0;
  logic       rx_empty = 1'b1;
  logic [7:0] rdata, w_data;
  logic       ack, busy, rd_uart, wr_uart;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  bit       e_ack [N];
  bit       e_busy[N];
  bit       e_rd  [N];
  bit       e_wr  [N];
  bit [7:0] e_rdata[N];
  bit [7:0] e_wdata[N];

  bit       m_block_en = 1'b1;
  bit       m_err = 1'b0;
  bit [7:0] m_rdata = 8'h00;

  mmio_uart_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy), .rd_uart(rd_uart), .wr_uart(wr_uart),
    .w_data(w_data), .r_data(r_data), .tx_full(tx_full), .rx_empty(rx_empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && cyc < N) begin
      chk("ack", {31'd0, ack}, {31'd0, e_ack[cyc]});
      chk("busy", {31'd0, busy}, {31'd0, e_busy[cyc]});
      chk("rd_uart", {31'd0, rd_uart}, {31'd0, e_rd[cyc]});
      chk("wr_uart", {31'd0, wr_uart}, {31'd0, e_wr[cyc]});
      if (e_ack[cyc]) chk("rdata", {24'd0, rdata}, {24'd0, e_rdata[cyc]});
      if (e_wr[cyc])  chk("w_data", {24'd0, w_data}, {24'd0, e_wdata[cyc]});
    end
  end

  // One access, issued at a negedge. The FIFO flags stay as they are for `hold`
  // decision cycles, then switch to the rel_* values.
  task automatic access(input logic w, input logic [1:0] a, input logic [7:0] d,
                        input int hold, input logic rel_full, input logic rel_empty,
                        input logic [7:0] rel_rdata, input bit extra,
                        output logic [7:0] got, output int lat);
    int p, j;
    bit ok, done;
    logic f, e;
    logic [7:0] rv;
    p = cyc + 1;
    j = 0;
    ok = 1'b0;
    done = 1'b0;
    f = tx_full;
    e = rx_empty;
    rv = r_data;
    while (!done) begin
      f  = (j < hold) ? tx_full  : rel_full;
      e  = (j < hold) ? rx_empty : rel_empty;
      rv = (j < hold) ? r_data   : rel_rdata;
      if (a != 2'd0 || (w ? !f : !e)) begin
        ok = 1'b1; done = 1'b1;
      end else if (!m_block_en || j == T - 1) begin
        ok = 1'b0; done = 1'b1;
      end else begin
        j++;
      end
    end
    if (!w) begin
      case (a)
        2'd0:    m_rdata = ok ? rv : 8'h00;
        2'd1:    m_rdata = {4'b0000, m_err, m_block_en, f, e};
        2'd2:    m_rdata = {7'b0000000, m_block_en};
        default: m_rdata = 8'h00;
      endcase
    end
    if (a == 2'd0 && !ok) m_err = 1'b1;
    if (w && a == 2'd2) begin
      m_block_en = d[0];
      if (d[1]) m_err = 1'b0;
    end
    for (int k = p; k <= p + 2 + j; k++) e_busy[k] = 1'b1;
    if (a == 2'd0 && ok) begin
      if (w) begin
        e_wr[p + 1 + j] = 1'b1;
        e_wdata[p + 1 + j] = d;
      end else begin
        e_rd[p + 1 + j] = 1'b1;
      end
    end
    e_ack[p + 2 + j] = 1'b1;
    e_rdata[p + 2 + j] = m_rdata;

    lat = -1;
    got = 8'h00;
    req = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
    if (ack && lat < 0) begin lat = cyc - p; got = rdata; end
    while (cyc < p + 2 + j) begin
      if (cyc == p + hold) begin
        tx_full = rel_full; rx_empty = rel_empty; r_data = rel_rdata;
      end
      req = (extra && cyc == p + 1);
      @(negedge clk);
      if (ack && lat < 0) begin lat = cyc - p; got = rdata; end
    end
    req = 1'b0;
  endtask

  // Blocking DATA read interrupted by rst while still waiting.
  task automatic abort_read();
    int p;
    p = cyc + 1;
    for (int k = p; k <= p + 2; k++) e_busy[k] = 1'b1;
    req = 1'b1; we = 1'b0; addr = 2'd0;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_rdata", {24'd0, rdata}, 32'h00);
    chk("abort_w_data", {24'd0, w_data}, 32'h00);
    m_block_en = 1'b1;
    m_err = 1'b0;
    m_rdata = 8'h00;
  endtask

  initial begin
    logic [7:0] g;
    int l;
    repeat (3) @(negedge clk);
    chk("rst_rdata", {24'd0, rdata}, 32'h00);
    chk("rst_ack", {31'd0, ack}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_rd_uart", {31'd0, rd_uart}, 32'h0);
    chk("rst_wr_uart", {31'd0, wr_uart}, 32'h0);
    chk("rst_w_data", {24'd0, w_data}, 32'h00);
    rst = 1'b0;
    chk_en = 1'b1;

    access(1'b0, 2'd1, 8'h00, 0, 1'b0, 1'b1, 8'h00, 1'b0, g, l);
    chk("status_after_rst", {24'd0, g}, 32'h05);
    chk("status_latency", l, 32'd2);

    access(1'b1, 2'd0, 8'hA5, 0, 1'b0, 1'b1, 8'h00, 1'b0, g, l);
    chk("write_latency", l, 32'd2);

    access(1'b0, 2'd0, 8'h00, 10, 1'b0, 1'b0, 8'h3C, 1'b1, g, l);
    chk("blocking_read_data", {24'd0, g}, 32'h3C);
    chk("blocking_read_latency", l, 32'd12);
    rx_empty = 1'b1;
    access(1'b0, 2'd1, 8'h00, 0, 1'b0, 1'b1, 8'h3C, 1'b0, g, l);
    chk("status_no_err", {24'd0, g}, 32'h05);

    tx_full = 1'b1;
    access(1'b1, 2'd0, 8'h11, 100, 1'b1, 1'b1, 8'h3C, 1'b0, g, l);
    chk("timeout_latency", l, 32'd17);
    tx_full = 1'b0;
    access(1'b0, 2'd1, 8'h00, 0, 1'b0, 1'b1, 8'h3C, 1'b0, g, l);
    chk("status_err_set", {24'd0, g}, 32'h0D);
    access(1'b1, 2'd2, 8'h03, 0, 1'b0, 1'b1, 8'h3C, 1'b0, g, l);
    access(1'b0, 2'd1, 8'h00, 0, 1'b0, 1'b1, 8'h3C, 1'b0, g, l);
    chk("status_err_cleared", {24'd0, g}, 32'h05);

    tx_full = 1'b1;
    access(1'b1, 2'd0, 8'h5A, 15, 1'b0, 1'b1, 8'h3C, 1'b0, g, l);
    chk("last_cycle_write_latency", l, 32'd17);
    access(1'b0, 2'd1, 8'h00, 0, 1'b0, 1'b1, 8'h3C, 1'b0, g, l);
    chk("status_last_cycle_ok", {24'd0, g}, 32'h05);

    access(1'b1, 2'd2, 8'h00, 0, 1'b0, 1'b1, 8'h77, 1'b0, g, l);
    access(1'b0, 2'd0, 8'h00, 0, 1'b0, 1'b1, 8'h77, 1'b0, g, l);
    chk("nonblock_read_data", {24'd0, g}, 32'h00);
    chk("nonblock_read_latency", l, 32'd2);
    access(1'b0, 2'd1, 8'h00, 0, 1'b0, 1'b1, 8'h77, 1'b0, g, l);
    chk("status_nonblock_err", {24'd0, g}, 32'h09);
    access(1'b0, 2'd2, 8'h00, 0, 1'b0, 1'b1, 8'h77, 1'b0, g, l);
    chk("ctrl_read_0", {24'd0, g}, 32'h00);

    access(1'b1, 2'd2, 8'h01, 0, 1'b0, 1'b1, 8'h77, 1'b0, g, l);
    access(1'b0, 2'd2, 8'h00, 0, 1'b0, 1'b1, 8'h77, 1'b0, g, l);
    chk("ctrl_read_1", {24'd0, g}, 32'h01);
    access(1'b1, 2'd3, 8'hFF, 0, 1'b0, 1'b1, 8'h77, 1'b0, g, l);
    access(1'b0, 2'd3, 8'h00, 0, 1'b0, 1'b1, 8'h77, 1'b0, g, l);
    chk("reserved_read", {24'd0, g}, 32'h00);
    access(1'b1, 2'd1, 8'hFF, 0, 1'b0, 1'b1, 8'h77, 1'b0, g, l);
    access(1'b0, 2'd1, 8'h00, 0, 1'b0, 1'b1, 8'h77, 1'b0, g, l);
    chk("status_write_ignored", {24'd0, g}, 32'h0D);

    abort_read();
    access(1'b0, 2'd1, 8'h00, 0, 1'b0, 1'b1, 8'h77, 1'b0, g, l);
    chk("status_after_abort", {24'd0, g}, 32'h05);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
